// File: rtl/switch_pkg.sv
// Shared types and helpers for the N-port packet switch.
package switch_pkg;

  function automatic int dest_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {IN_ACCEPT, IN_DISCARD} in_state_t;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Framing flags stored alongside every buffered word.
  typedef struct packed {
    logic sop;
    logic eop;
  } frame_t;

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
module pkt_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [AW:0]      cnt;
  logic             doWr, doRd;

  assign doWr   = wrEn && !full;
  assign doRd   = rdEn && !empty;
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) rdPtr <= rdPtr + 1'b1;
      case ({doWr, doRd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (doWr) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/switch_nxn.sv
// N-port packet switch: per-input FIFO with legality filter, per-output
// packet-locked round-robin arbiter driving a registered output stage.
module switch_nxn
  import switch_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS*DATA_W-1:0]   in_data,
  input  logic [N_PORTS-1:0]          in_valid,
  input  logic [N_PORTS-1:0]          in_sop,
  input  logic [N_PORTS-1:0]          in_eop,
  output logic [N_PORTS-1:0]          in_stall,
  output logic [N_PORTS*DATA_W-1:0]   out_data,
  output logic [N_PORTS-1:0]          out_valid,
  output logic [N_PORTS-1:0]          out_sop,
  output logic [N_PORTS-1:0]          out_eop,
  output logic [N_PORTS*CNT_W-1:0]    drop_cnt,
  output logic [N_PORTS-1:0]          ovf
);
  localparam int DW = dest_w(N_PORTS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    frame_t              frm;
    logic [DATA_W-1:0]   data;
  } fifo_entry_t;

  fifo_entry_t [N_PORTS-1:0]                 head;
  logic [N_PORTS-1:0]                        wrEn, pop, full, empty;
  logic [N_PORTS-1:0][CW-1:0]                count;
  logic [N_PORTS-1:0][DW-1:0]                headDest;
  logic [N_PORTS-1:0][N_PORTS-1:0]           popSel;

  always_comb begin
    pop = '0;
    for (int o = 0; o < N_PORTS; o++) pop = pop | popSel[o];
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_in
    in_state_t          state, stateNxt;
    logic               inPkt, inPktNxt, wrReq, dropInc, legal;
    logic               stallR, ovfR;
    logic [CNT_W-1:0]   dropCntR;
    logic [DATA_W-1:0]  wd;
    fifo_entry_t        wrEntry;

    assign wd      = in_data[i*DATA_W +: DATA_W];
    assign legal   = ({1'b0, wd[DW-1:0]} < (DW+1)'(N_PORTS));
    assign wrEntry = {in_sop[i], in_eop[i], wd};

    always_comb begin
      stateNxt = state;
      inPktNxt = inPkt;
      wrReq    = 1'b0;
      dropInc  = 1'b0;
      if (in_valid[i]) begin
        case (state)
          IN_ACCEPT: begin
            if (in_sop[i]) begin
              if (legal) begin
                wrReq    = 1'b1;
                inPktNxt = !in_eop[i];
              end else begin
                dropInc  = 1'b1;
                inPktNxt = 1'b0;
                if (!in_eop[i]) stateNxt = IN_DISCARD;
              end
            end else if (inPkt) begin
              // Words outside a packet (no preceding legal sop) fall through here unwritten.
              wrReq = 1'b1;
              if (in_eop[i]) inPktNxt = 1'b0;
            end
          end
          IN_DISCARD: if (in_eop[i]) stateNxt = IN_ACCEPT;
          default:    stateNxt = IN_ACCEPT;
        endcase
      end
    end

    assign wrEn[i] = wrReq;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= IN_ACCEPT;
        inPkt    <= 1'b0;
        stallR   <= 1'b0;
        ovfR     <= 1'b0;
        dropCntR <= '0;
      end else begin
        state  <= stateNxt;
        inPkt  <= inPktNxt;
        stallR <= (count[i] >= CW'(FIFO_DEPTH - 2));
        if (wrReq && full[i]) ovfR <= 1'b1;
        if (dropInc && (dropCntR != '1)) dropCntR <= dropCntR + 1'b1;
      end
    end

    pkt_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wrEn   (wrReq),
      .wrData (wrEntry),
      .rdEn   (pop[i]),
      .rdData (head[i]),
      .count  (count[i]),
      .full   (full[i]),
      .empty  (empty[i])
    );

    assign headDest[i]                   = head[i].data[DW-1:0];
    assign in_stall[i]                   = stallR;
    assign ovf[i]                        = ovfR;
    assign drop_cnt[i*CNT_W +: CNT_W]    = dropCntR;
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    arb_state_t          st, stNxt;
    logic [DW-1:0]       owner, ownerNxt, lastG, lastGNxt, gnt, sel;
    logic [N_PORTS-1:0]  req, popVec;
    logic                found, take, holdOff;
    logic [DATA_W-1:0]   outData_p1;
    logic                vld_p1, outSop_p1, outEop_p1;

    always_comb begin
      for (int i = 0; i < N_PORTS; i++)
        req[i] = !empty[i] && head[i].frm.sop && (headDest[i] == DW'(o));
    end

    always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      gnt   = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
        idx = int'(lastG) + k;
        if (idx >= N_PORTS) idx = idx - N_PORTS;
        if (!found && req[DW'(idx)]) begin
          found = 1'b1;
          gnt   = DW'(idx);
        end
      end
    end

    // The cycle after an eop leaves the output is spent idle before re-arbitrating.
    assign holdOff = vld_p1 && outEop_p1;

    always_comb begin
      stNxt    = st;
      ownerNxt = owner;
      lastGNxt = lastG;
      take     = 1'b0;
      sel      = owner;
      case (st)
        ARB_IDLE: begin
          if (found && !holdOff) begin
            take     = 1'b1;
            sel      = gnt;
            ownerNxt = gnt;
            lastGNxt = gnt;
            if (!head[gnt].frm.eop) stNxt = ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!empty[owner]) begin
            take = 1'b1;
            if (head[owner].frm.eop) stNxt = ARB_IDLE;
          end
        end
        default: stNxt = ARB_IDLE;
      endcase
    end

    always_comb begin
      popVec = '0;
      if (take) popVec[sel] = 1'b1;
    end

    assign popSel[o] = popVec;

    // ---- stage p1: registered output word ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st         <= ARB_IDLE;
        owner      <= '0;
        lastG      <= DW'(N_PORTS - 1);
        vld_p1     <= 1'b0;
        outSop_p1  <= 1'b0;
        outEop_p1  <= 1'b0;
        outData_p1 <= '0;
      end else begin
        st         <= stNxt;
        owner      <= ownerNxt;
        lastG      <= lastGNxt;
        vld_p1     <= take;
        outSop_p1  <= take && head[sel].frm.sop;
        outEop_p1  <= take && head[sel].frm.eop;
        if (take) outData_p1 <= head[sel].data;
      end
    end

    assign out_data[o*DATA_W +: DATA_W] = outData_p1;
    assign out_valid[o]                 = vld_p1;
    assign out_sop[o]                   = outSop_p1;
    assign out_eop[o]                   = outEop_p1;
  end

endmodule

// File: tb/tb_switch_nxn.sv
// Directed bench for switch_nxn with five ports (destinations 5..7 are illegal).
module tb_switch_nxn;
  localparam int N  = 5;
  localparam int DWD = 32;
  localparam int DEP = 16;
  localparam int CNW = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*DWD-1:0]   in_data;
  logic [N-1:0]       in_valid, in_sop, in_eop, in_stall;
  logic [N*DWD-1:0]   out_data;
  logic [N-1:0]       out_valid, out_sop, out_eop, ovf;
  logic [N*CNW-1:0]   drop_cnt;

  switch_nxn #(.N_PORTS(N), .DATA_W(DWD), .FIFO_DEPTH(DEP), .CNT_W(CNW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_stall(in_stall), .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .drop_cnt(drop_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    bit          s;
    bit          e;
    int          c;
  } rec_t;

  rec_t q[N][$];

  always @(negedge clk) begin
    for (int o = 0; o < N; o++)
      if (out_valid[o] === 1'b1)
        q[o].push_back('{out_data[o*DWD +: DWD], out_sop[o], out_eop[o], cyc});
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] d, input bit s, input bit e, input int c);
    return '{d, s, e, c};
  endfunction

  task automatic checkOut(input string tag, input int o, input rec_t exp[$]);
    check($sformatf("%s.n", tag), q[o].size(), exp.size());
    for (int k = 0; k < exp.size() && k < q[o].size(); k++) begin
      check($sformatf("%s.d%0d", tag, k), q[o][k].d, exp[k].d);
      check($sformatf("%s.sop%0d", tag, k), q[o][k].s, exp[k].s);
      check($sformatf("%s.eop%0d", tag, k), q[o][k].e, exp[k].e);
      if (exp[k].c >= 0) check($sformatf("%s.cyc%0d", tag, k), q[o][k].c, exp[k].c);
    end
  endtask

  function automatic int otherWords(input int keep);
    int n = 0;
    for (int o = 0; o < N; o++) if (o != keep) n += q[o].size();
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [31:0] d, input bit s, input bit e);
    in_data[p*DWD +: DWD] = d;
    in_valid[p] = 1'b1;
    in_sop[p]   = s;
    in_eop[p]   = e;
  endtask

  task automatic idle(input int p);
    in_valid[p] = 1'b0;
    in_sop[p]   = 1'b0;
    in_eop[p]   = 1'b0;
  endtask

  task automatic clearQ();
    for (int o = 0; o < N; o++) q[o].delete();
  endtask

  function automatic logic [31:0] bpWord(input int k);
    return (k == 0) ? 32'hE000_0001 : 32'hE100_0000 + 32'(k);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t exp[$];
    int   s, sent, guard;
    bit   stallSeen;

    rst = 1'b1;
    in_data = '0; in_valid = '0; in_sop = '0; in_eop = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", out_valid, 0);
    check("rst.stall", in_stall, 0);
    check("rst.ovf", ovf, 0);
    check("rst.drop", drop_cnt, 0);
    check("rst.data", out_data, 0);
    rst = 1'b0;
    tick();

    // Single 4-word packet port 0 -> out 2.
    clearQ();
    s = cyc;
    drive(0, 32'hA000_0002, 1, 0); tick();
    drive(0, 32'hA111_1111, 0, 0); tick();
    drive(0, 32'hA222_2222, 0, 0); tick();
    drive(0, 32'hA333_3333, 0, 1); tick();
    idle(0);
    repeat (6) tick();
    exp = {};
    exp.push_back(mk(32'hA000_0002, 1, 0, s + 2));
    exp.push_back(mk(32'hA111_1111, 0, 0, s + 3));
    exp.push_back(mk(32'hA222_2222, 0, 0, s + 4));
    exp.push_back(mk(32'hA333_3333, 0, 1, s + 5));
    checkOut("single", 2, exp);
    check("single.others", otherWords(2), 0);

    // Contention on out 0, two rounds; port 1 wins both times.
    for (int r = 0; r < 2; r++) begin
      logic [31:0] b1, b3;
      b1 = (r == 0) ? 32'h1000_0000 : 32'h1100_0000;
      b3 = (r == 0) ? 32'h3000_0000 : 32'h3300_0000;
      clearQ();
      s = cyc;
      drive(1, b1, 1, 0);        drive(3, b3, 1, 0);        tick();
      drive(1, b1 + 32'h10, 0, 0); drive(3, b3 + 32'h10, 0, 0); tick();
      drive(1, b1 + 32'h20, 0, 1); drive(3, b3 + 32'h20, 0, 1); tick();
      idle(1); idle(3);
      repeat (10) tick();
      exp = {};
      exp.push_back(mk(b1,          1, 0, s + 2));
      exp.push_back(mk(b1 + 32'h10, 0, 0, s + 3));
      exp.push_back(mk(b1 + 32'h20, 0, 1, s + 4));
      exp.push_back(mk(b3,          1, 0, s + 6));
      exp.push_back(mk(b3 + 32'h10, 0, 0, s + 7));
      exp.push_back(mk(b3 + 32'h20, 0, 1, s + 8));
      checkOut($sformatf("contend%0d", r), 0, exp);
    end

    // Illegal destinations, stray no-sop word, then a legal packet.
    clearQ();
    drive(0, 32'hBAD0_0006, 1, 0); tick();
    drive(0, 32'hBAD0_0101, 0, 0); tick();
    drive(0, 32'hBAD0_0102, 0, 0); tick();
    drive(0, 32'hBAD0_0103, 0, 0); tick();
    drive(0, 32'hBAD0_0104, 0, 1); tick();
    idle(0); tick();
    check("illegal.drop1", drop_cnt[0 +: CNW], 1);
    drive(0, 32'hBAD1_0007, 1, 1); tick();
    drive(0, 32'h0000_0004, 0, 0); tick();
    s = cyc;
    drive(0, 32'hC000_0004, 1, 0); tick();
    drive(0, 32'hC000_0005, 0, 1); tick();
    idle(0);
    repeat (6) tick();
    exp = {};
    exp.push_back(mk(32'hC000_0004, 1, 0, s + 2));
    exp.push_back(mk(32'hC000_0005, 0, 1, s + 3));
    checkOut("legal", 4, exp);
    check("illegal.others", otherWords(4), 0);
    check("illegal.drop2", drop_cnt[0 +: CNW], 2);
    check("illegal.dropRest", drop_cnt[CNW +: 4*CNW], 0);

    // Back-pressure: out 1 held by an open packet from port 0 while port 2 streams.
    clearQ();
    drive(0, 32'hD000_0001, 1, 0); tick();
    drive(0, 32'hD000_0011, 0, 0); tick();
    drive(0, 32'hD000_0012, 0, 0); tick();
    idle(0);
    sent = 0;
    stallSeen = 0;
    while (sent < 20 && !stallSeen) begin
      if (in_stall[2]) begin
        idle(2);
        stallSeen = 1;
      end else begin
        drive(2, bpWord(sent), sent == 0, sent == 19);
        sent++;
        tick();
      end
    end
    idle(2);
    check("bp.sentAtStall", sent, 15);
    check("bp.stall", in_stall[2], 1);
    check("bp.ovf", ovf[2], 0);
    drive(0, 32'hD000_0013, 0, 1); tick();
    idle(0);
    guard = 0;
    while (sent < 20 && guard < 200) begin
      if (in_stall[2]) idle(2);
      else begin
        drive(2, bpWord(sent), 0, sent == 19);
        sent++;
      end
      tick();
      guard++;
    end
    idle(2);
    check("bp.allSent", sent, 20);
    repeat (40) tick();
    exp = {};
    exp.push_back(mk(32'hD000_0001, 1, 0, -1));
    exp.push_back(mk(32'hD000_0011, 0, 0, -1));
    exp.push_back(mk(32'hD000_0012, 0, 0, -1));
    exp.push_back(mk(32'hD000_0013, 0, 1, -1));
    for (int k = 0; k < 20; k++) exp.push_back(mk(bpWord(k), k == 0, k == 19, -1));
    checkOut("bp", 1, exp);
    check("bp.ovfEnd", ovf, 0);

    // Overflow: port 4 ignores stall while out 3 is held by port 1.
    clearQ();
    drive(1, 32'hF100_0003, 1, 0); tick();
    idle(1);
    for (int k = 0; k < 18; k++) begin
      drive(4, (k == 0) ? 32'hF400_0003 : 32'hF400_0100 + 32'(k), k == 0, k == 17);
      tick();
    end
    idle(4);
    repeat (3) tick();
    check("ovf.set", ovf[4], 1);
    check("ovf.others", ovf[3:0], 0);
    drive(1, 32'hF100_0004, 0, 1); tick();
    idle(1);
    repeat (30) tick();
    exp = {};
    exp.push_back(mk(32'hF100_0003, 1, 0, -1));
    exp.push_back(mk(32'hF100_0004, 0, 1, -1));
    for (int k = 0; k < 16; k++)
      exp.push_back(mk((k == 0) ? 32'hF400_0003 : 32'hF400_0100 + 32'(k), k == 0, 0, -1));
    checkOut("ovf", 3, exp);

    // Reset asserted while out 2 is mid-packet.
    drive(0, 32'h7000_0002, 1, 0); tick();
    for (int k = 1; k <= 3; k++) begin
      drive(0, 32'h7000_0010 + 32'(k), 0, 0);
      tick();
    end
    check("mrst.before", out_valid[2], 1);
    #2 rst = 1'b1;
    #1;
    check("mrst.valid", out_valid, 0);
    check("mrst.sop", out_sop, 0);
    check("mrst.eop", out_eop, 0);
    check("mrst.data", out_data, 0);
    check("mrst.drop", drop_cnt, 0);
    check("mrst.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    clearQ();
    tick();
    drive(0, 32'h7000_0020, 0, 0); tick();
    drive(0, 32'h7000_0021, 0, 1); tick();
    idle(0);
    repeat (6) tick();
    check("mrst.tailDropped", otherWords(-1), 0);
    check("mrst.dropStill0", drop_cnt[0 +: CNW], 0);
    s = cyc;
    drive(3, 32'h7300_0002, 1, 0); tick();
    drive(3, 32'h7300_0003, 0, 1); tick();
    idle(3);
    repeat (6) tick();
    exp = {};
    exp.push_back(mk(32'h7300_0002, 1, 0, s + 2));
    exp.push_back(mk(32'h7300_0003, 0, 1, s + 3));
    checkOut("postrst", 2, exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
